// File: rtl/sasa_tile_softmax_pre.sv
// sasa_tile_softmax_pre: loads diagonal BLK x BLK score tiles, finds each tile max and streams score - max.
// Optional SASA_SAT_EN clamps results below -2^(DATA_W-1) to that value.
module sasa_tile_softmax_pre #(
   parameter int DATA_W    = 8,
   parameter int BLK       = 4,
   parameter int NUM_TILES = 4,
   parameter int ADDR_W    = 4
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            start,
   output logic                                            busy,
   output logic                                            done,
   output logic                                            data_req,
   output logic [ADDR_W-1:0]                               data_addr_x,
   output logic [ADDR_W-1:0]                               data_addr_y,
   input  logic [DATA_W-1:0]                               data_in,
   input  logic                                            data_valid,
   output logic [DATA_W:0]                                 out_data,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic                                            out_last,
   output logic [(NUM_TILES > 1 ? $clog2(NUM_TILES) : 1)-1:0] tile_idx
);
   localparam int N  = BLK * BLK;
   localparam int LB = $clog2(BLK);
   localparam int EW = 2 * LB;
   localparam int TW = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, FINDMAX, SUB, DONE} state_t;

   state_t            state, state_n;
   logic [EW-1:0]     elem, elem_n;
   logic [TW-1:0]     tile_n;
   logic [DATA_W-1:0] mx;
   logic [DATA_W-1:0] buffer [N];
   logic [DATA_W:0]   diff;
   logic              last;

   assign last        = elem == EW'(N - 1);
   assign busy        = state != IDLE;
   assign done        = state == DONE;
   assign data_req    = state == LOAD;
   assign out_valid   = state == SUB;
   assign out_last    = out_valid && last;
   assign data_addr_x = ADDR_W'({tile_idx, elem[LB-1:0]});
   assign data_addr_y = ADDR_W'({tile_idx, elem[EW-1:LB]});
   assign diff        = {buffer[elem][DATA_W-1], buffer[elem]} - {mx[DATA_W-1], mx};
`ifdef SASA_SAT_EN
   assign out_data = !out_valid ? '0 :
                     (diff[DATA_W] && !diff[DATA_W-1]) ? {2'b11, {(DATA_W-1){1'b0}}} : diff;
`else
   assign out_data = out_valid ? diff : '0;
`endif

   // Tile buffer: written only on accepted source beats, never reset
   always_ff @(posedge clk) begin
      if (data_req && data_valid) buffer[elem] <= data_in;
   end

   // State, element/tile counters and running signed maximum
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         elem     <= '0;
         tile_idx <= '0;
         mx       <= '0;
      end else begin
         state    <= state_n;
         elem     <= elem_n;
         tile_idx <= tile_n;
         if (state == FINDMAX)
            mx <= (elem == '0 || $signed(buffer[elem]) > $signed(mx)) ? buffer[elem] : mx;
      end
   end

   // Next state; counters only move on accepted beats in LOAD and SUB
   always_comb begin
      state_n = state;
      elem_n  = elem;
      tile_n  = tile_idx;
      case (state)
         IDLE: if (start) begin
            state_n = LOAD;
            elem_n  = '0;
            tile_n  = '0;
         end
         LOAD: if (data_valid) begin
            elem_n  = last ? '0 : elem + 1'b1;
            state_n = last ? FINDMAX : LOAD;
         end
         FINDMAX: begin
            elem_n  = last ? '0 : elem + 1'b1;
            state_n = last ? SUB : FINDMAX;
         end
         SUB: if (out_ready) begin
            elem_n = last ? '0 : elem + 1'b1;
            if (last && tile_idx == TW'(NUM_TILES - 1)) state_n = DONE;
            else if (last) begin
               state_n = LOAD;
               tile_n  = tile_idx + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            tile_n  = '0;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sasa_tile_softmax_pre.sv
// tb_sasa_tile_softmax_pre: directed checks of load addressing, max finding, subtraction, stalls and reset.
module tb_sasa_tile_softmax_pre;
   localparam int N = 16;

   logic       clk = 1'b0;
   logic       reset, start, data_valid, out_ready;
   logic [7:0] data_in;
   logic       busy, done, data_req, out_valid, out_last;
   logic [3:0] data_addr_x, data_addr_y;
   logic [8:0] out_data;
   logic [0:0] tile_idx;

   logic signed [7:0] tiles [2][N];
   int n_chk = 0;
   int n_fail = 0;

   sasa_tile_softmax_pre #(.DATA_W(8), .BLK(4), .NUM_TILES(2), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .data_req(data_req), .data_addr_x(data_addr_x), .data_addr_y(data_addr_y),
      .data_in(data_in), .data_valid(data_valid), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .tile_idx(tile_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_req"}, data_req, 0);
      chk({tag, "_addr"}, {data_addr_x, data_addr_y}, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_tile"}, tile_idx, 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_load(input int t, input bit gaps, input bit pulse_start);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            data_valid = 1'b0;
            @(negedge clk);
         end
         chk("load_req", data_req, 1);
         chk("load_busy", busy, 1);
         chk("addr_x", data_addr_x, t * 4 + i % 4);
         chk("addr_y", data_addr_y, t * 4 + i / 4);
         data_valid = 1'b1;
         data_in    = tiles[t][i];
         start      = pulse_start && i == 3;
         @(negedge clk);
         start = 1'b0;
      end
      data_valid = 1'b0;
   endtask

   task automatic do_findmax();
      for (int i = 0; i < N; i++) begin
         chk("fm_valid", out_valid, 0);
         chk("fm_req", data_req, 0);
         @(negedge clk);
      end
   endtask

   task automatic do_sub(input int t, input bit stall, input int stop_at);
      logic signed [7:0] mx;
      logic [8:0] e;
      mx = tiles[t][0];
      for (int k = 1; k < N; k++) if (tiles[t][k] > mx) mx = tiles[t][k];
      for (int i = 0; i < N; i++) begin
         if (i == stop_at) return;
         e = {tiles[t][i][7], tiles[t][i]} - {mx[7], mx};
`ifdef SASA_SAT_EN
         if (e[8] && !e[7]) e = 9'h180;
`endif
         chk("sub_valid", out_valid, 1);
         chk("sub_data", out_data, e);
         chk("sub_last", out_last, i == N - 1);
         chk("sub_tile", tile_idx, t);
         if (stall && i == 5) begin
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, e);
               chk("stall_last", out_last, 0);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic finish_run();
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_tile", tile_idx, 0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      out_ready  = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      // Basic run: ramp tile, then all -128 tile
      for (int k = 0; k < N; k++) begin
         tiles[0][k] = 8'(k);
         tiles[1][k] = -8'sd128;
      end
      do_start();
      do_load(0, 1'b0, 1'b0);
      do_findmax();
      do_sub(0, 1'b0, N);
      do_load(1, 1'b0, 1'b0);
      do_findmax();
      do_sub(1, 1'b0, N);
      finish_run();

      // Ties with negatives, then extreme values
      for (int k = 0; k < N; k++) begin
         tiles[0][k] = 8'(k - 10);
         tiles[1][k] = '0;
      end
      tiles[0][0] = -8'sd5;
      tiles[0][1] = 8'sd7;
      tiles[0][2] = 8'sd7;
      tiles[0][3] = 8'sd3;
      tiles[1][0] = -8'sd128;
      tiles[1][1] = 8'sd127;
      do_start();
      do_load(0, 1'b0, 1'b0);
      do_findmax();
      chk("tie_beat0", out_data, 9'h1F4);
      do_sub(0, 1'b0, N);
      do_load(1, 1'b0, 1'b0);
      do_findmax();
`ifdef SASA_SAT_EN
      chk("extreme_beat0", out_data, 9'h180);
`else
      chk("extreme_beat0", out_data, 9'h101);
`endif
      do_sub(1, 1'b0, N);
      finish_run();

      // Gaps, stall and start during LOAD; reset during tile1 SUB
      for (int k = 0; k < N; k++) tiles[0][k] = 8'(k);
      do_start();
      do_load(0, 1'b1, 1'b1);
      do_findmax();
      do_sub(0, 1'b1, N);
      do_load(1, 1'b1, 1'b0);
      do_findmax();
      do_sub(1, 1'b0, 6);
      reset = 1'b1;
      #1;
      chk_idle_outputs("abort");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_idle", busy, 0);
      end

      // Restart after reset begins at tile0 address (0,0)
      do_start();
      do_load(0, 1'b0, 1'b0);
      do_findmax();
      do_sub(0, 1'b0, N);
      do_load(1, 1'b0, 1'b0);
      do_findmax();
      do_sub(1, 1'b0, N);
      finish_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sasa_tile_softmax_pre.md
Name: sasa_tile_softmax_pre

Overview:
- Parametrised successor of the SASA CAM1 front end.
- Walks NUM_TILES diagonal BLK×BLK tiles of the QK score map. Each tile is fetched through a req/valid address interface into a local buffer.
- Finds the tile maximum with an internal signed comparator instead of an external CAM.
- Streams max-subtracted scores (softmax pre-normalisation) over a valid/ready interface to the downstream exp/LUT stage.

Parameters:
- DATA_W, 8: score width, signed two's complement.
- BLK, 4: tile side; tile holds BLK*BLK elements; power of 2, ≥2.
- NUM_TILES, 4: diagonal tiles processed per start.
- ADDR_W, 4: width of data_addr_x/y; must satisfy BLK*NUM_TILES ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output of the last tile is accepted.
- data_req  out  1  high in LOAD; address is valid.
- data_addr_x  out  ADDR_W  column address = tile_idx*BLK + col.
- data_addr_y  out  ADDR_W  row address = tile_idx*BLK + row.
- data_in  in  DATA_W  score; captured when data_req && data_valid.
- data_valid  in  1  source beat strobe; may gap arbitrarily.
- out_data  out  DATA_W+1  signed buffer[i] − tile_max, always ≤ 0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with the last beat of each tile.
- tile_idx  out  clog2(NUM_TILES)  current tile index.

Behaviour:
- Reset values: all outputs 0; state IDLE; tile_idx 0; counters 0; max 0. Buffer contents need not be reset. Reset mid-run aborts immediately; no done pulse.
- States and transitions:
  - IDLE: start → LOAD, with tile_idx=0, elem=0.
  - LOAD:
    - data_req=1; row = elem / BLK, col = elem % BLK (row-major order).
    - On data_req && data_valid: buffer[elem] ← data_in; elem++.
    - On the beat where elem==BLK*BLK−1 is accepted: elem←0 → FINDMAX.
    - Address advances only on accepted beats and holds stable during data_valid gaps.
  - FINDMAX:
    - One element per cycle; running max ← buffer[0] at elem=0, then signed max(max, buffer[elem]).
    - Takes exactly BLK*BLK cycles; at elem==BLK*BLK−1: elem←0 → SUB.
  - SUB:
    - out_valid=1; out_data = sext(buffer[elem]) − sext(max), computed at DATA_W+1 bits with no overflow possible.
    - Advance elem only on out_valid && out_ready. out_data, out_last and tile_idx hold stable while stalled.
    - out_last=1 when elem==BLK*BLK−1.
    - On the last accepted beat: if tile_idx==NUM_TILES−1 → DONE; else tile_idx++, elem←0 → LOAD.
  - DONE: done=1 for one cycle; tile_idx←0 → IDLE. busy stays 1 during DONE.
- Ties in max: value only, no index reported.
- start while busy: ignored, with no effect on the current run.
- Latency per tile, with no gaps and no stalls: BLK*BLK (LOAD) + BLK*BLK (FINDMAX) + BLK*BLK (SUB) cycles.
- First out_valid occurs 2*BLK*BLK cycles after LOAD is entered.

Optional Feature:
- Macro: SASA_SAT_EN.
- Defined: out_data is clamped so that any result below −2^(DATA_W−1) outputs −2^(DATA_W−1). The exp stage then only needs a DATA_W-range LUT. Port width is unchanged.
- Undefined: full DATA_W+1 result; minimum is −(2^DATA_W − 1).

Test Plan (BLK=4, NUM_TILES=2, DATA_W=8):
- Basic run:
  - Stimulus: start; tile0 scores 0..15 row-major, data_valid always high; out_ready=1.
  - Response: addresses (x,y) sweep 0..3; tile_max=15; out_data −15..0 in order; out_last on beat 16.
  - Tile1 then loads with addresses 4..7; done pulses once after tile1's 16th accepted beat.
- Negative and tie values:
  - Stimulus: tile of all −128.
  - Response: every out_data=0.
  - Stimulus: tile {−5, 7, 7, 3, ...}.
  - Response: max=7; beat0 = −12.
- Extreme values:
  - Stimulus: tile with −128 and 127.
  - Response without SASA_SAT_EN: −255 for the −128 element.
  - Response with SASA_SAT_EN: −128 for the −128 element.
- Stalls and gaps:
  - Stimulus: data_valid toggling 1/0; out_ready low for 3 cycles at beat 5.
  - Response: address and out_data/out_last held stable through gaps and stalls; no beat lost or duplicated; same results as the Basic run.
- Reset and start while busy:
  - Stimulus: reset asserted during tile1 SUB.
  - Response: all outputs 0 immediately; IDLE; no done pulse.
  - Stimulus: new start after reset.
  - Response: restarts at tile0 address (0,0).
  - Stimulus: start pulsed during LOAD.
  - Response: no effect on the run.
